// File: rtl/irfan_tinysnn.sv
// irfan_tinysnn: 8-input, 8-neuron LIF spiking layer with 2-bit signed weights behind the TT pin interface.
module irfan_tinysnn #(
  parameter int          LEAK_SHIFT = 4,
  parameter logic [5:0]  THR_RESET  = 6'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [127:0]      w;
  logic [5:0]        thr;
  logic signed [7:0] v [8];
  logic [7:0]        spike;
  logic signed [5:0] sum [8];
  logic signed [9:0] vn [8];
  logic signed [7:0] v_sat [8];
  logic [7:0]        fire;
  logic              cfg_en, cfg_sel;
  logic [5:0]        data;
  assign cfg_en  = uio_in[7];
  assign cfg_sel = uio_in[6];
  assign data    = uio_in[5:0];
  // Arithmetic is done on explicitly sign-extended vectors so the 10-bit sum cannot wrap.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      sum[n] = '0;
      for (int i = 0; i < 8; i++)
        sum[n] = ui_in[i] ? sum[n] + {{4{w[(n*8+i)*2+1]}}, w[(n*8+i)*2 +: 2]} : sum[n];
      vn[n] = {{2{v[n][7]}}, v[n]} - {{2{v[n][7]}}, 8'(v[n] >>> LEAK_SHIFT)} + {{4{sum[n][5]}}, sum[n]};
      v_sat[n] = vn[n] > 10'sd127 ? 8'sd127 : vn[n] < -10'sd128 ? -8'sd128 : vn[n][7:0];
      fire[n] = vn[n] >= $signed({4'b0, thr});
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w     <= {64{2'b01}};
      thr   <= THR_RESET;
      spike <= '0;
      for (int n = 0; n < 8; n++) v[n] <= '0;
    end else if (ena) begin
      if (cfg_en) begin
        spike <= '0;
        if (!cfg_sel) w <= {w[125:0], data[1:0]};
        else begin
          thr <= data;
          for (int n = 0; n < 8; n++) v[n] <= '0;
        end
      end else begin
        spike <= fire;
        for (int n = 0; n < 8; n++) v[n] <= fire[n] ? 8'sd0 : v_sat[n];
      end
    end
  end
  assign uo_out  = (!cfg_en && cfg_sel) ? v[data[5:3]] : spike;
  assign uio_out = '0;
  assign uio_oe  = '0;
endmodule

// File: tb/tb_irfan_tinysnn.sv
// tb_irfan_tinysnn: random and directed stimulus scored against an integer LIF reference model.
module tb_irfan_tinysnn;
  logic       clk = 0, rst_n = 0, ena = 0;
  logic [7:0] ui_in = 0, uio_in = 0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int errors = 0, checks = 0;
  int mw [64];
  int mv [8];
  int mthr;
  logic [7:0] msp;
  typedef struct { logic [7:0] exp; string tag; } exp_t;
  exp_t q[$];

  irfan_tinysnn dut (.clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
                     .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe));

  always #5 clk = ~clk;

  function automatic void chk(string t, logic [7:0] a, logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", t, a, e, $time);
    end
  endfunction

  function automatic void mreset();
    foreach (mw[k]) mw[k] = 1;
    foreach (mv[n]) mv[n] = 0;
    mthr = 4;
    msp = 0;
  endfunction

  // floor(v / 2^LEAK_SHIFT) with LEAK_SHIFT = 4
  function automatic int leak(int v);
    return v < 0 ? -((-v + 15) / 16) : v / 16;
  endfunction

  // weights kept as a list indexed n*8+i; a config shift pushes new values in at index 0
  function automatic void mstep(bit e, logic [7:0] ui, logic [7:0] c);
    int s, x;
    if (!e) return;
    if (c[7]) begin
      msp = 0;
      if (!c[6]) begin
        for (int k = 63; k > 0; k--) mw[k] = mw[k-1];
        mw[0] = c[1] ? int'(c[1:0]) - 4 : int'(c[1:0]);
      end else begin
        mthr = int'(c[5:0]);
        foreach (mv[n]) mv[n] = 0;
      end
    end else begin
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int i = 0; i < 8; i++) if (ui[i]) s += mw[n*8+i];
        x = mv[n] - leak(mv[n]) + s;
        x = x > 127 ? 127 : x < -128 ? -128 : x;
        msp[n] = x >= mthr;
        mv[n]  = x >= mthr ? 0 : x;
      end
    end
  endfunction

  function automatic logic [7:0] mout(logic [7:0] c);
    return (!c[7] && c[6]) ? 8'(mv[c[5:3]]) : msp;
  endfunction

  task automatic cyc(bit e, logic [7:0] ui, logic [7:0] c, string tag);
    @(negedge clk);
    ena = e; ui_in = ui; uio_in = c;
    mstep(e, ui, c);
    q.push_back('{mout(c), tag});
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() != 0) begin
      x = q.pop_front();
      chk(x.tag, uo_out, x.exp);
      chk("uio_const", uio_out | uio_oe, 8'h00);
    end
  end

  initial begin
    logic [31:0] r;
    mreset();
    #2;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio", uio_out | uio_oe, 8'h00);
    @(negedge clk); rst_n = 1;
    cyc(1, 8'hFF, 8'h00, "t1_fire");
    cyc(1, 8'h00, 8'h00, "t1_quiet");
    cyc(1, 8'h00, 8'h40, "t1_mon_v0");
    for (int k = 0; k < 9; k++) cyc(1, 8'h01, k[0] ? 8'h40 : 8'h00, "t2_single");
    repeat (56) cyc(1, 8'h00, 8'h81, "t3_cfg");
    repeat (8)  cyc(1, 8'h00, 8'h82, "t3_cfg");
    repeat (4)  cyc(1, 8'hFF, 8'h00, "t3_spk");
    repeat (14) cyc(1, 8'hFF, 8'h40, "t3_mon_sat");
    cyc(1, 8'h00, 8'hD0, "t4_thr");
    repeat (3)  cyc(1, 8'hFF, 8'h48, "t4_mon");
    repeat (2)  cyc(1, 8'hFF, 8'h00, "t4_spk");
    cyc(1, 8'h00, 8'hFF, "t5_thr");
    repeat (4)  cyc(1, 8'hFF, 8'h48, "t5_rise");
    repeat (5)  cyc(1, 8'h00, 8'h48, "t5_decay");
    repeat (3)  cyc(1, 8'hFF, 8'h48, "t5_pre");
    repeat (3)  cyc(0, 8'hFF, 8'h48, "t6_freeze");
    @(posedge clk); #3;
    rst_n = 0; #1;
    chk("async_rst", uo_out, 8'h00);
    mreset();
    @(negedge clk); rst_n = 1;
    cyc(1, 8'hFF, 8'h00, "t6_post_rst");
    cyc(1, 8'h01, 8'h00, "t6_post_rst2");
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      cyc($urandom_range(0, 9) != 0, 8'($urandom),
          r[31:27] == 0 ? {2'b11, r[5:0]} : r[31:27] < 4 ? {6'b100000, r[1:0]} : {1'b0, r[6:0]},
          "rand");
    end
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
